mult_div_seq: RTL and testbench

//  Iterative signed multiply/divide engine that sequences and arbitrates the shared
//  HI/LO datapath resource used by MULT and DIV. Control_unit pulses a start, then

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_div_step.sv | 30 +++
 rtl/mult_div_seq.sv | 164 ++++++++++++++++
 tb/tb_mult_div_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM state
// encodings, counter sizing and the op-select code used by Control_unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  // Counter wide enough to hold WIDTH-1 with headroom for the terminal compare.
  localparam int CNT_W     = $clog2(MDU_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } mdu_state_e;

  // Op-select code shared with Control_unit when it decodes MULT/DIV.
  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } mdu_op_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on magnitudes: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, and keep the
// difference only if it did not go negative.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtract; bit WIDTH of the difference is the borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    if (trial[WIDTH]) begin
      rem_o = shifted;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine.
// One iteration per cycle over WIDTH cycles; results land in hi/lo as the
// FSM enters FIN, where done pulses for one cycle.
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // Same sizing rule as mdu_pkg::CNT_W, applied to this instance's width.
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic             qm1_q, qm1_d;     // Booth q(-1) bit
  logic             qneg_q, qneg_d;   // quotient must be negated
  logic             rneg_q, rneg_d;   // remainder takes dividend's sign
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH:0]   m_ext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_mq;
  logic             booth_qm1;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_quo;

  // Booth step: add/subtract the sign-extended multiplicand, then shift the
  // whole {acc, mq, q-1} chain right arithmetically by one.
  always_comb begin
    m_ext = {opnd_q[WIDTH-1], opnd_q};
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    {booth_acc, booth_mq, booth_qm1} = {booth_sum[WIDTH], booth_sum, mq_q};
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[WIDTH-1:0]),
    .quo_i (mq_q),
    .dvs_i (opnd_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // Next-state and datapath update; results are written on the FIN entry edge.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    qm1_d   = qm1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        acc_d  = '0;
        qm1_d  = 1'b0;
        div0_d = 1'b0;
        if (mult_start) begin
          state_d = MULT;
          mq_d    = b_in;
          opnd_d  = a_in;
        end else if (div_start) begin
          if (b_in != '0) begin
            state_d = DIV;
            mq_d    = a_in[WIDTH-1] ? -a_in : a_in;
            opnd_d  = b_in[WIDTH-1] ? -b_in : b_in;
            qneg_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rneg_d  = a_in[WIDTH-1];
          end else begin
            state_d = FIN;
            div0_d  = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d = booth_acc;
        mq_d  = booth_mq;
        qm1_d = booth_qm1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FIN;
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_mq;
        end
      end
      DIV: begin
        acc_d = div_rem;
        mq_d  = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FIN;
          lo_d    = qneg_q ? -div_quo : div_quo;
          hi_d    = rneg_q ? -div_rem[WIDTH-1:0] : div_rem[WIDTH-1:0];
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset of all state and accumulators.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      qm1_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      qm1_q   <= qm1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy   = (state_q == MULT) || (state_q == DIV);
  assign done   = (state_q == FIN);
  assign div0   = (state_q == FIN) && div0_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: a scoreboard queue receives the
// expected {hi, lo, div0} at each start; a negedge monitor pops on done.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start, div_start;
  logic [31:0] a_in, b_in;
  logic        busy, done, div0;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mult_div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .div0       (div0),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every done must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done t=%0t: hi=%h lo=%h div0=%b, expected no done",
                 $time, hi_out, lo_out, div0);
      end else begin
        mon_e = sb_q.pop_front();
        total += 3;
        if (hi_out !== mon_e.hi) begin
          bad++;
          $display("FAIL result_hi t=%0t: got %h want %h", $time, hi_out, mon_e.hi);
        end
        if (lo_out !== mon_e.lo) begin
          bad++;
          $display("FAIL result_lo t=%0t: got %h want %h", $time, lo_out, mon_e.lo);
        end
        if (div0 !== mon_e.div0) begin
          bad++;
          $display("FAIL result_div0 t=%0t: got %b want %b", $time, div0, mon_e.div0);
        end
      end
    end
  end

  // Reference model built on 64-bit integer arithmetic.
  function automatic exp_t model(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, p, ma, mb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.div0 = 1'b0;
    if (is_mult) begin
      p    = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      q  = ma / mb;
      if ((sa < 0) != (sb < 0)) q = -q;
      r    = sa - q * sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Called at a negedge with the FSM idle: drives one start, follows it to
  // done, checks busy in every cycle and the done cycle, and leaves the bench
  // at the negedge of the first idle cycle after FIN.
  task automatic run_op(input string name, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input int want_cyc, input logic pulse_div);
    int cyc;
    int got;
    int busy_bad;
    bit seen;
    mult_start = m;
    div_start  = d;
    a_in       = a;
    b_in       = b;
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    cyc = 1; got = -1; busy_bad = 0; seen = 0;
    while (!seen && cyc <= 40) begin
      a_in = $urandom;
      b_in = pulse_div ? 32'd9 : $urandom;
      if (busy !== (cyc < want_cyc)) busy_bad++;
      if (done === 1'b1) begin
        seen = 1;
        got  = cyc;
      end
      div_start = pulse_div && (cyc == 5 || seen);
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    div_start = 1'b0;
    total += 3;
    if (got != want_cyc) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, got, want_cyc);
    end
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL %s busy_profile: %0d wrong cycles, want 0", name, busy_bad);
    end
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse_width: done=%b one cycle after done, want 0", name, done);
    end
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.div0 = dz;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mult_start = 1'b0; div_start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    total += 5;
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    if (div0 !== 1'b0)    begin bad++; $display("FAIL reset_div0: got %b want 0", div0); end
    if (hi_out !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi_out); end
    if (lo_out !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 33, 1'b0);
    push(32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("mult_max_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 1'b0);
    push(32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("mult_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 1'b0);
  endtask

  task automatic test_div();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);
    push(32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0);
    push(32'h0000_0011, 32'h0000_0022, 1'b0);
    run_op("div_451_20", 1'b0, 1'b1, 32'h0000_0451, 32'h0000_0020, 33, 1'b0);
  endtask

  // Relies on hi/lo = 0x11/0x22 left by the last divide of test_div.
  task automatic test_div0();
    push(32'h0000_0011, 32'h0000_0022, 1'b1);
    run_op("div_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 1, 1'b0);
    total += 2;
    if (hi_out !== 32'h11) begin bad++; $display("FAIL div0_hold_hi: got %h want 00000011", hi_out); end
    if (lo_out !== 32'h22) begin bad++; $display("FAIL div0_hold_lo: got %h want 00000022", lo_out); end
  endtask

  task automatic test_simultaneous();
    push(32'h0, 32'd12, 1'b0);
    run_op("mult_wins", 1'b1, 1'b1, 32'd3, 32'd4, 33, 1'b1);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mult_start = 1'b1; a_in = 32'h1234_5678; b_in = 32'h0BAD_CAFE;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total += 4;
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_mid_done: got %b want 0", done); end
    if (hi_out !== 32'h0) begin bad++; $display("FAIL reset_mid_hi: got %h want 0", hi_out); end
    if (lo_out !== 32'h0) begin bad++; $display("FAIL reset_mid_lo: got %h want 0", lo_out); end
    repeat (40) @(negedge clk);
    push(32'd2, 32'd14, 1'b0);
    run_op("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 33, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        m;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i >= 6) b = {{24{b[7]}}, b[7:0]};  // small divisor, larger quotients
      m = i[0];
      if (!m && b == '0) b = 32'd1;
      sb_q.push_back(model(m, a, b));
      run_op(m ? "rand_mult" : "rand_div", m, !m, a, b, 33, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
